// File: rtl/hcsr04_pkg.sv
// Shared types and constants for the multi-channel HC-SR04 interface.
package hcsr04_pkg;

    localparam int BCD_W = 12;
    localparam logic [BCD_W-1:0] BCD_SAT = 12'h999;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        ESPERA_ECHO,
        MEDINDO,
        ARMAZENA,
        PROX_CANAL,
        FIM,
        INTERVALO
    } estado_t;

    // Three-digit BCD increment that holds at 999.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == BCD_SAT) begin
            return v;
        end
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

endpackage

// File: rtl/contador_bcd_cm.sv
// Divides echo-high cycles by R_CM and accumulates whole centimetres in
// a saturating 3-digit BCD counter. One instance serves every channel.
module contador_bcd_cm
    import hcsr04_pkg::*;
#(
    parameter int R_CM = 2941
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [BCD_W-1:0] bcd_o
);

    localparam int DW = (R_CM > 1) ? $clog2(R_CM) : 1;

    logic [DW-1:0]    div_q;
    logic [BCD_W-1:0] bcd_q;

    // Cycle divider and BCD accumulator; clear wins over enable.
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            bcd_q <= '0;
        end else if (clr_i) begin
            div_q <= '0;
            bcd_q <= '0;
        end else if (en_i) begin
            if (div_q == DW'(R_CM - 1)) begin
                div_q <= '0;
                bcd_q <= bcd_inc(bcd_q);
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/interface_hcsr04_multi.sv
// Scans CANAIS HC-SR04 sensors in turn: trigger, wait for echo, time the
// echo, store a BCD distance (or 999 on timeout), then move to the next.
module interface_hcsr04_multi
    import hcsr04_pkg::*;
#(
    parameter int CANAIS           = 4,
    parameter int TRIG_CICLOS      = 500,
    parameter int R_CM             = 2941,
    parameter int TIMEOUT_CICLOS   = 1_500_000,
    parameter int INTERVALO_CICLOS = 3_000_000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              medir,
    input  logic                              continuo,
    input  logic [CANAIS-1:0]                 echo,
    output logic [CANAIS-1:0]                 trigger,
    output logic [BCD_W*CANAIS-1:0]           distancia,
    output logic [CANAIS-1:0]                 timeout,
    output logic [$clog2(CANAIS)-1:0]         canal,
    output logic                              ocupado,
    output logic                              pronto
);

    localparam int CW   = $clog2(CANAIS);
    localparam int TM1  = (TRIG_CICLOS > TIMEOUT_CICLOS) ? TRIG_CICLOS : TIMEOUT_CICLOS;
    localparam int TMAX = (TM1 > INTERVALO_CICLOS) ? TM1 : INTERVALO_CICLOS;
    localparam int TW   = $clog2(TMAX + 1);

    estado_t                  state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [CW-1:0]            canal_q, canal_d;
    logic                     to_q, to_d;
    logic [CANAIS-1:0]        echo_s1_q, echo_s2_q;
    logic [BCD_W*CANAIS-1:0]  distancia_q;
    logic [CANAIS-1:0]        timeout_q;
    logic [BCD_W-1:0]         bcd;
    logic                     echo_sel;
    logic                     cnt_clr, cnt_en, store;

    assign echo_sel = echo_s2_q[canal_q];

    // Two-flop synchroniser for the asynchronous echo inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
        end
    end

    // FSM state, shared timer, channel index and timeout condition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            canal_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            canal_q <= canal_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; the timer restarts at zero on every state change.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        canal_d = canal_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                to_d = 1'b0;
                if (medir) begin
                    state_d = TRIGGER;
                    canal_d = '0;
                end
            end
            TRIGGER: begin
                if (timer_q == TW'(TRIG_CICLOS - 1)) state_d = ESPERA_ECHO;
            end
            ESPERA_ECHO: begin
                if (echo_sel) begin
                    state_d = MEDINDO;
                end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    state_d = ARMAZENA;
                    to_d    = 1'b1;
                end
            end
            MEDINDO: begin
                if (!echo_sel) begin
                    state_d = ARMAZENA;
                end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    state_d = ARMAZENA;
                    to_d    = 1'b1;
                end
            end
            ARMAZENA: state_d = PROX_CANAL;
            PROX_CANAL: begin
                to_d = 1'b0;
                if (canal_q == CW'(CANAIS - 1)) begin
                    state_d = FIM;
                end else begin
                    state_d = TRIGGER;
                    canal_d = canal_q + 1'b1;
                end
            end
            FIM: state_d = continuo ? INTERVALO : IDLE;
            INTERVALO: begin
                if (!continuo) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(INTERVALO_CICLOS - 1)) begin
                    state_d = TRIGGER;
                    canal_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + 1'b1;
    end

    // Moore outputs and datapath controls decoded from the current state.
    always_comb begin
        trigger = '0;
        if (state_q == TRIGGER) trigger[canal_q] = 1'b1;
        ocupado = (state_q != IDLE);
        pronto  = (state_q == FIM);
        cnt_clr = (state_q == IDLE) || (state_q == PROX_CANAL);
        cnt_en  = ((state_q == ESPERA_ECHO) || (state_q == MEDINDO)) && echo_sel;
        store   = (state_q == ARMAZENA);
    end

    contador_bcd_cm #(.R_CM(R_CM)) u_contador (
        .clock (clock),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .bcd_o (bcd)
    );

    // Result registers: only the selected channel is written, only in ARMAZENA.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            distancia_q <= '0;
            timeout_q   <= '0;
        end else if (store) begin
            distancia_q[canal_q*BCD_W +: BCD_W] <= to_q ? BCD_SAT : bcd;
            timeout_q[canal_q]                  <= to_q;
        end
    end

    assign distancia = distancia_q;
    assign timeout   = timeout_q;
    assign canal     = canal_q;

endmodule
